// File: rtl/multicycle_ctrl_if.sv
// Datapath-facing bus of the multi-cycle RV32I controller: opcode/memory handshake in, datapath enables out.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_sel_data;
  logic       ir_write;
  logic       alu_src;
  logic [1:0] alu_op;
  logic       mem_to_reg;
  logic [1:0] jump;
  logic       branch_eval;
  logic       reg_write;
  logic       pc_write;
  logic       retire;
  logic       fault;
  logic [2:0] state;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, mem_sel_data, ir_write, alu_src, alu_op, mem_to_reg,
           jump, branch_eval, reg_write, pc_write, retire, fault, state
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, mem_sel_data, ir_write, alu_src, alu_op, mem_to_reg,
           jump, branch_eval, reg_write, pc_write, retire, fault, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with sticky FAULT on illegal opcode or memory timeout.
// Optional MC_CTRL_PERF_EN adds cycle_cnt / retired_cnt performance counters.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_FAULT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
  } class_t;

  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     r_state, w_next;
  class_t     r_class, w_dec_class;
  logic [7:0] r_wait;

  logic       w_mem_req, w_mem_we, w_mem_sel_data, w_ir_write, w_alu_src, w_mem_to_reg;
  logic       w_branch_eval, w_reg_write, w_pc_write, w_retire, w_fault;
  logic [1:0] w_alu_op, w_jump;
  logic [1:0] w_cls_alu_op, w_cls_jump;
  logic       w_cls_alu_src;
  logic       w_wait_expired;

  always_comb begin
    case (bus.opcode)
      7'b0110011: w_dec_class = C_R;
      7'b0010011: w_dec_class = C_I;
      7'b0000011: w_dec_class = C_LOAD;
      7'b0100011: w_dec_class = C_STORE;
      7'b1100011: w_dec_class = C_BRANCH;
      7'b1101111: w_dec_class = C_JAL;
      7'b1100111: w_dec_class = C_JALR;
      7'b0110111: w_dec_class = C_LUI;
      7'b0010111: w_dec_class = C_AUIPC;
      default:    w_dec_class = C_ILL;
    endcase
  end

  always_comb begin
    w_cls_alu_op  = 2'b00;
    w_cls_alu_src = 1'b0;
    w_cls_jump    = 2'b00;
    case (r_class)
      C_R:      w_cls_alu_op = 2'b10;
      C_I:      begin w_cls_alu_op = 2'b10; w_cls_alu_src = 1'b1; end
      C_BRANCH: w_cls_alu_op = 2'b01;
      C_JAL:    w_cls_jump = 2'b10;
      C_JALR:   begin w_cls_alu_src = 1'b1; w_cls_jump = 2'b01; end
      C_LOAD, C_STORE, C_LUI, C_AUIPC: w_cls_alu_src = 1'b1;
      default:  ;
    endcase
  end

  assign w_wait_expired = (r_wait == LP_LAST_WAIT);

  // Completion strobes (ir_write, store retire) follow the memory handshake so they fire exactly once.
  always_comb begin
    w_next         = r_state;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_sel_data = 1'b0;
    w_ir_write     = 1'b0;
    w_alu_src      = 1'b0;
    w_alu_op       = 2'b00;
    w_mem_to_reg   = 1'b0;
    w_jump         = 2'b00;
    w_branch_eval  = 1'b0;
    w_reg_write    = 1'b0;
    w_pc_write     = 1'b0;
    w_retire       = 1'b0;
    w_fault        = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_wait_expired) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: w_next = (w_dec_class == C_ILL) ? S_FAULT : S_EXECUTE;
      S_EXECUTE: begin
        w_alu_op  = w_cls_alu_op;
        w_alu_src = w_cls_alu_src;
        w_jump    = w_cls_jump;
        case (r_class)
          C_BRANCH: begin
            w_branch_eval = 1'b1;
            w_pc_write    = 1'b1;
            w_retire      = 1'b1;
            w_next        = S_FETCH;
          end
          C_LOAD, C_STORE: w_next = S_MEM;
          default:         w_next = S_WB;
        endcase
      end
      S_MEM: begin
        w_mem_req      = 1'b1;
        w_mem_sel_data = 1'b1;
        w_mem_we       = (r_class == C_STORE);
        w_alu_op       = w_cls_alu_op;
        w_alu_src      = w_cls_alu_src;
        if (bus.mem_ready) begin
          if (r_class == C_STORE) begin
            w_pc_write = 1'b1;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_wait_expired) begin
          w_next = S_FAULT;
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        w_retire     = 1'b1;
        w_mem_to_reg = (r_class == C_LOAD);
        w_jump       = w_cls_jump;
        w_next       = S_FETCH;
      end
      S_FAULT: w_fault = 1'b1;
      default: w_next = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_class <= C_ILL;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_class <= w_dec_class;
      if (w_next != r_state) r_wait <= 8'd0;
      else if (w_mem_req && !bus.mem_ready) r_wait <= r_wait + 8'd1;
    end
  end

  assign bus.mem_req      = w_mem_req      & ~reset;
  assign bus.mem_we       = w_mem_we       & ~reset;
  assign bus.mem_sel_data = w_mem_sel_data & ~reset;
  assign bus.ir_write     = w_ir_write     & ~reset;
  assign bus.alu_src      = w_alu_src      & ~reset;
  assign bus.alu_op       = reset ? 2'b00 : w_alu_op;
  assign bus.mem_to_reg   = w_mem_to_reg   & ~reset;
  assign bus.jump         = reset ? 2'b00 : w_jump;
  assign bus.branch_eval  = w_branch_eval  & ~reset;
  assign bus.reg_write    = w_reg_write    & ~reset;
  assign bus.pc_write     = w_pc_write     & ~reset;
  assign bus.retire       = w_retire       & ~reset;
  assign bus.fault        = w_fault        & ~reset;
  assign bus.state        = reset ? 3'd0 : r_state;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt, r_retired_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt   <= 32'd0;
      r_retired_cnt <= 32'd0;
    end else if (r_state != S_FAULT) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire) r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes hand-computed per-cycle output vectors, a monitor pops and compares.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MC_CTRL_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
`endif
  );

  typedef struct packed {
    logic       req;
    logic       we;
    logic       sel;
    logic       ir;
    logic       src;
    logic [1:0] op;
    logic       m2r;
    logic [1:0] jmp;
    logic       be;
    logic       rw;
    logic       pw;
    logic       ret;
    logic       flt;
    logic [2:0] st;
  } exp_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_BAD = 7'b0000000;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic exp_t ev(input logic req, input logic we, input logic sel, input logic ir,
                              input logic src, input logic [1:0] op, input logic m2r,
                              input logic [1:0] jmp, input logic be, input logic rw,
                              input logic pw, input logic ret, input logic flt, input logic [2:0] st);
    exp_t e;
    e.req = req; e.we = we; e.sel = sel; e.ir = ir; e.src = src; e.op = op; e.m2r = m2r;
    e.jmp = jmp; e.be = be; e.rw = rw; e.pw = pw; e.ret = ret; e.flt = flt; e.st = st;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s.req = bus.mem_req; s.we = bus.mem_we; s.sel = bus.mem_sel_data; s.ir = bus.ir_write;
    s.src = bus.alu_src; s.op = bus.alu_op; s.m2r = bus.mem_to_reg; s.jmp = bus.jump;
    s.be = bus.branch_eval; s.rw = bus.reg_write; s.pw = bus.pc_write; s.ret = bus.retire;
    s.flt = bus.fault; s.st = bus.state;
    return s;
  endfunction

  // Common vectors (field order: req we sel ir src op m2r jmp be rw pw ret flt st)
  exp_t E_ZERO, E_FETCH_RDY, E_FETCH_WAIT, E_DEC, E_FAULT, E_WB_PLAIN;
  initial begin
    E_ZERO       = ev(0,0,0,0,0,2'b00,0,2'b00,0,0,0,0,0,3'd0);
    E_FETCH_RDY  = ev(1,0,0,1,0,2'b00,0,2'b00,0,0,0,0,0,3'd0);
    E_FETCH_WAIT = ev(1,0,0,0,0,2'b00,0,2'b00,0,0,0,0,0,3'd0);
    E_DEC        = ev(0,0,0,0,0,2'b00,0,2'b00,0,0,0,0,0,3'd1);
    E_FAULT      = ev(0,0,0,0,0,2'b00,0,2'b00,0,0,0,0,1,3'd7);
    E_WB_PLAIN   = ev(0,0,0,0,0,2'b00,0,2'b00,0,1,1,1,0,3'd4);
  end

  task automatic cyc(input logic rst, input logic [6:0] op, input logic rdy, input exp_t e,
                     input string tag);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic run_r(input string tag);
    cyc(0, OP_R, 1, E_FETCH_RDY, {tag, "_fetch"});
    cyc(0, OP_R, 1, E_DEC, {tag, "_decode"});
    cyc(0, OP_R, 1, ev(0,0,0,0,0,2'b10,0,2'b00,0,0,0,0,0,3'd2), {tag, "_exec"});
    cyc(0, OP_R, 1, E_WB_PLAIN, {tag, "_wb"});
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle
  initial begin
    exp_t  e, a;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = sample();
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got %b required %b (state got %0d req %0d)", t, a, e, a.st, e.st);
        end
      end
    end
  end

  initial begin
    bus.opcode    = OP_R;
    bus.mem_ready = 1'b0;

    // Reset: all outputs low
    cyc(1, OP_R, 1, E_ZERO, "reset_a");
    cyc(1, OP_R, 1, E_ZERO, "reset_b");

    // R-type, ready high: 4 cycles
    run_r("r1");

    // LOAD, 3 wait cycles in MEM, ready on the TIMEOUT-th cycle
    cyc(0, OP_LD, 1, E_FETCH_RDY, "ld_fetch");
    cyc(0, OP_LD, 1, E_DEC, "ld_decode");
    cyc(0, OP_LD, 1, ev(0,0,0,0,1,2'b00,0,2'b00,0,0,0,0,0,3'd2), "ld_exec");
    for (int i = 0; i < 3; i++)
      cyc(0, OP_LD, 0, ev(1,0,1,0,1,2'b00,0,2'b00,0,0,0,0,0,3'd3), "ld_mem_wait");
    cyc(0, OP_LD, 1, ev(1,0,1,0,1,2'b00,0,2'b00,0,0,0,0,0,3'd3), "ld_mem_rdy");
    cyc(0, OP_LD, 1, ev(0,0,0,0,0,2'b00,1,2'b00,0,1,1,1,0,3'd4), "ld_wb");

    // STORE, ready high: retires in MEM on cycle 4
    cyc(0, OP_ST, 1, E_FETCH_RDY, "st_fetch");
    cyc(0, OP_ST, 1, E_DEC, "st_decode");
    cyc(0, OP_ST, 1, ev(0,0,0,0,1,2'b00,0,2'b00,0,0,0,0,0,3'd2), "st_exec");
    cyc(0, OP_ST, 1, ev(1,1,1,0,1,2'b00,0,2'b00,0,0,1,1,0,3'd3), "st_mem");

    // STORE with one wait: no retire until ready
    cyc(0, OP_ST, 1, E_FETCH_RDY, "st2_fetch");
    cyc(0, OP_ST, 1, E_DEC, "st2_decode");
    cyc(0, OP_ST, 1, ev(0,0,0,0,1,2'b00,0,2'b00,0,0,0,0,0,3'd2), "st2_exec");
    cyc(0, OP_ST, 0, ev(1,1,1,0,1,2'b00,0,2'b00,0,0,0,0,0,3'd3), "st2_mem_wait");
    cyc(0, OP_ST, 1, ev(1,1,1,0,1,2'b00,0,2'b00,0,0,1,1,0,3'd3), "st2_mem_rdy");

    // BRANCH: resolves in EXECUTE
    cyc(0, OP_BR, 1, E_FETCH_RDY, "br_fetch");
    cyc(0, OP_BR, 1, E_DEC, "br_decode");
    cyc(0, OP_BR, 1, ev(0,0,0,0,0,2'b01,0,2'b00,1,0,1,1,0,3'd2), "br_exec");

    // JAL / JALR / I-ALU / LUI / AUIPC
    cyc(0, OP_JAL, 1, E_FETCH_RDY, "jal_fetch");
    cyc(0, OP_JAL, 1, E_DEC, "jal_decode");
    cyc(0, OP_JAL, 1, ev(0,0,0,0,0,2'b00,0,2'b10,0,0,0,0,0,3'd2), "jal_exec");
    cyc(0, OP_JAL, 1, ev(0,0,0,0,0,2'b00,0,2'b10,0,1,1,1,0,3'd4), "jal_wb");
    cyc(0, OP_JALR, 1, E_FETCH_RDY, "jalr_fetch");
    cyc(0, OP_JALR, 1, E_DEC, "jalr_decode");
    cyc(0, OP_JALR, 1, ev(0,0,0,0,1,2'b00,0,2'b01,0,0,0,0,0,3'd2), "jalr_exec");
    cyc(0, OP_JALR, 1, ev(0,0,0,0,0,2'b00,0,2'b01,0,1,1,1,0,3'd4), "jalr_wb");
    cyc(0, OP_I, 1, E_FETCH_RDY, "ialu_fetch");
    cyc(0, OP_I, 1, E_DEC, "ialu_decode");
    cyc(0, OP_I, 1, ev(0,0,0,0,1,2'b10,0,2'b00,0,0,0,0,0,3'd2), "ialu_exec");
    cyc(0, OP_I, 1, E_WB_PLAIN, "ialu_wb");
    cyc(0, OP_LUI, 1, E_FETCH_RDY, "lui_fetch");
    cyc(0, OP_LUI, 1, E_DEC, "lui_decode");
    cyc(0, OP_LUI, 1, ev(0,0,0,0,1,2'b00,0,2'b00,0,0,0,0,0,3'd2), "lui_exec");
    cyc(0, OP_LUI, 1, E_WB_PLAIN, "lui_wb");
    cyc(0, OP_AUIPC, 1, E_FETCH_RDY, "auipc_fetch");
    cyc(0, OP_AUIPC, 1, E_DEC, "auipc_decode");
    cyc(0, OP_AUIPC, 1, ev(0,0,0,0,1,2'b00,0,2'b00,0,0,0,0,0,3'd2), "auipc_exec");
    cyc(0, OP_AUIPC, 1, E_WB_PLAIN, "auipc_wb");

    // FETCH waits 3 cycles, ready on the 4th wins over timeout
    for (int i = 0; i < 3; i++)
      cyc(0, OP_R, 0, E_FETCH_WAIT, "fetch_wait");
    run_r("r_late");

    // Reset mid-MEM aborts the LOAD, then refetch
    cyc(0, OP_LD, 1, E_FETCH_RDY, "abort_fetch");
    cyc(0, OP_LD, 1, E_DEC, "abort_decode");
    cyc(0, OP_LD, 1, ev(0,0,0,0,1,2'b00,0,2'b00,0,0,0,0,0,3'd2), "abort_exec");
    cyc(0, OP_LD, 0, ev(1,0,1,0,1,2'b00,0,2'b00,0,0,0,0,0,3'd3), "abort_mem");
    cyc(1, OP_LD, 1, E_ZERO, "abort_reset");
    run_r("refetch");

    // Illegal opcode: sticky FAULT, mem_ready ignored
    cyc(0, OP_BAD, 1, E_FETCH_RDY, "ill_fetch");
    cyc(0, OP_BAD, 1, E_DEC, "ill_decode");
    for (int i = 0; i < 20; i++)
      cyc(0, OP_BAD, logic'(i % 2), E_FAULT, "ill_fault");
    cyc(1, OP_R, 1, E_ZERO, "ill_reset");
    run_r("post_fault");

    // FETCH timeout after 4 wait cycles
    for (int i = 0; i < 4; i++)
      cyc(0, OP_R, 0, E_FETCH_WAIT, "to_wait");
    for (int i = 0; i < 3; i++)
      cyc(0, OP_R, 1, E_FAULT, "to_fault");
    cyc(1, OP_R, 1, E_ZERO, "to_reset");
    run_r("post_timeout");

`ifdef MC_CTRL_PERF_EN
    cyc(1, OP_R, 1, E_ZERO, "perf_reset");
    for (int i = 0; i < 10; i++) run_r("perf_r");
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (retired_cnt !== 32'd10) begin
      n_bad++;
      $display("FAIL perf_retired: got %0d required 10", retired_cnt);
    end
    force dut.r_cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle_cnt;
    @(negedge clk);
    n_cmp++;
    if (cycle_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_cycle_wrap: got %h required 00000000", cycle_cnt);
    end
`endif

    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
